// File: rtl/seq_pkg.sv
// Shared opcodes, ALUOp encodings and state/class enums for the sequencer.
// Used by seq_decode and mc_sequencer.
package seq_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [1:0] ALUOP_MEM   = 2'b00;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_IDLE  = 2'b00;

    typedef enum logic [2:0] {
        IDLE,
        DECODE,
        EXEC,
        MEM,
        WB
    } state_t;

    typedef enum logic [1:0] {
        CLS_RTYPE,
        CLS_LW,
        CLS_SW,
        CLS_ILLEGAL
    } iclass_t;

endpackage

// File: rtl/seq_decode.sv
// Combinational opcode decoder: OP field -> instruction class, ALUOp,
// illegal flag.
module seq_decode
    import seq_pkg::*;
(
    input  logic [5:0] op,
    output iclass_t    iclass,
    output logic [1:0] alu_op,
    output logic       illegal
);

    always_comb begin
        iclass  = CLS_ILLEGAL;
        alu_op  = ALUOP_IDLE;
        illegal = 1'b1;
        unique case (op)
            OP_RTYPE: begin
                iclass  = CLS_RTYPE;
                alu_op  = ALUOP_RTYPE;
                illegal = 1'b0;
            end
            OP_LW: begin
                iclass  = CLS_LW;
                alu_op  = ALUOP_MEM;
                illegal = 1'b0;
            end
            OP_SW: begin
                iclass  = CLS_SW;
                alu_op  = ALUOP_MEM;
                illegal = 1'b0;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mc_sequencer.sv
// Multi-cycle control sequencer (IDLE/DECODE/EXEC/MEM/WB) with registered
// datapath controls. SEQ_RETIRE_CNT_EN enables the retired-instruction counter.
module mc_sequencer
    import seq_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [31:0] instr,
    input  logic        alu_zf,
    output logic        RegWrite,
    output logic        MemToRead,
    output logic        MemToWrite,
    output logic        MemToReg,
    output logic [1:0]  ALUOp,
    output logic [4:0]  ra1,
    output logic [4:0]  ra2,
    output logic [4:0]  wa,
    output logic [5:0]  funct,
    output logic        done,
    output logic        zf_out,
    output logic        err,
    output logic [15:0] retired_cnt
);

    state_t     state;
    iclass_t    cls;
    iclass_t    dec_cls;
    logic [1:0] dec_alu_op;
    logic       dec_illegal;
    logic [4:0] rs_q;
    logic [4:0] rt_q;
    logic [4:0] rd_q;
    logic [5:0] funct_q;
    logic       unused_shamt;

    seq_decode u_decode (
        .op      (instr[31:26]),
        .iclass  (dec_cls),
        .alu_op  (dec_alu_op),
        .illegal (dec_illegal)
    );

    assign unused_shamt = ^instr[10:6];

    assign ra1   = rs_q;
    assign ra2   = rt_q;
    assign funct = funct_q;
    assign wa    = (cls == CLS_RTYPE) ? rd_q : rt_q;

    // Outputs are computed for the state being entered, so they are
    // registered alongside it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cls         <= CLS_ILLEGAL;
            rs_q        <= '0;
            rt_q        <= '0;
            rd_q        <= '0;
            funct_q     <= '0;
            zf_out      <= 1'b0;
            instr_ready <= 1'b0;
            RegWrite    <= 1'b0;
            MemToRead   <= 1'b0;
            MemToWrite  <= 1'b0;
            MemToReg    <= 1'b0;
            ALUOp       <= ALUOP_IDLE;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            RegWrite    <= 1'b0;
            MemToRead   <= 1'b0;
            MemToWrite  <= 1'b0;
            MemToReg    <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            instr_ready <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (instr_valid && instr_ready) begin
                        rs_q    <= instr[25:21];
                        rt_q    <= instr[20:16];
                        rd_q    <= instr[15:11];
                        funct_q <= instr[5:0];
                        cls     <= dec_cls;
                        ALUOp   <= dec_alu_op;
                        err     <= dec_illegal;
                        state   <= DECODE;
                    end else begin
                        instr_ready <= 1'b1;
                        ALUOp       <= ALUOP_IDLE;
                    end
                end
                DECODE: begin
                    if (cls == CLS_ILLEGAL) begin
                        state       <= IDLE;
                        instr_ready <= 1'b1;
                        ALUOp       <= ALUOP_IDLE;
                    end else begin
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    zf_out <= alu_zf;
                    case (cls)
                        CLS_RTYPE: begin
                            state    <= WB;
                            RegWrite <= 1'b1;
                            done     <= 1'b1;
                        end
                        CLS_LW: begin
                            state     <= MEM;
                            MemToRead <= 1'b1;
                            MemToReg  <= 1'b1;
                        end
                        default: begin
                            state      <= MEM;
                            MemToWrite <= 1'b1;
                            done       <= 1'b1;
                        end
                    endcase
                end
                MEM: begin
                    if (cls == CLS_LW) begin
                        state     <= WB;
                        RegWrite  <= 1'b1;
                        MemToRead <= 1'b1;
                        MemToReg  <= 1'b1;
                        done      <= 1'b1;
                    end else begin
                        state       <= IDLE;
                        instr_ready <= 1'b1;
                        ALUOp       <= ALUOP_IDLE;
                    end
                end
                WB: begin
                    state       <= IDLE;
                    instr_ready <= 1'b1;
                    ALUOp       <= ALUOP_IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SEQ_RETIRE_CNT_EN
    logic [15:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (done) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign retired_cnt = cnt_q;
`else
    assign retired_cnt = '0;
`endif

endmodule

// File: tb/tb_mc_sequencer.sv
// Self-checking bench for mc_sequencer: directed scenarios plus random
// instruction streams checked against a per-instruction stage-plan model.
module tb_mc_sequencer;

    localparam int S_DEC = 0;
    localparam int S_EXE = 1;
    localparam int S_MEM = 2;
    localparam int S_WB  = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic        alu_zf;
    logic        RegWrite;
    logic        MemToRead;
    logic        MemToWrite;
    logic        MemToReg;
    logic [1:0]  ALUOp;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [4:0]  wa;
    logic [5:0]  funct;
    logic        done;
    logic        zf_out;
    logic        err;
    logic [15:0] retired_cnt;

    int          tests = 0;
    int          fails = 0;
    logic        m_zf;
    logic [15:0] m_cnt;
    logic        zf_force_en = 1'b0;
    logic        zf_force_val = 1'b0;

    logic [8:0]  ctl;
    logic [46:0] all_out;

    assign ctl = {instr_ready, RegWrite, MemToRead, MemToWrite, MemToReg,
                  ALUOp, done, err};
    assign all_out = {instr_ready, RegWrite, MemToRead, MemToWrite, MemToReg,
                      ALUOp, ra1, ra2, wa, funct, done, zf_out, err,
                      retired_cnt};

    always #5 clk = ~clk;

    mc_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .alu_zf      (alu_zf),
        .RegWrite    (RegWrite),
        .MemToRead   (MemToRead),
        .MemToWrite  (MemToWrite),
        .MemToReg    (MemToReg),
        .ALUOp       (ALUOp),
        .ra1         (ra1),
        .ra2         (ra2),
        .wa          (wa),
        .funct       (funct),
        .done        (done),
        .zf_out      (zf_out),
        .err         (err),
        .retired_cnt (retired_cnt)
    );

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [8:0] exp_ctl(input bit rdy, input bit rw,
                                           input bit mr, input bit mw,
                                           input bit m2r, input logic [1:0] aop,
                                           input bit dn, input bit er);
        return {rdy, rw, mr, mw, m2r, aop, dn, er};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_ctl"}, 64'(ctl), 64'(exp_ctl(1, 0, 0, 0, 0, 2'b00, 0, 0)));
        check({tag, "_zf"}, 64'(zf_out), 64'(m_zf));
        check({tag, "_cnt"}, 64'(retired_cnt), 64'(m_cnt));
    endtask

    task automatic idle_cycles(input int g);
        for (int i = 0; i < g; i++) begin
            instr_valid = 1'b0;
            instr = $urandom();
            tick();
            check_idle("gap");
        end
    endtask

    // Handshake in the current IDLE cycle, then follow the stage plan.
    task automatic run_instr(input logic [31:0] ins);
        logic [5:0] op;
        bit         is_r, is_lw, is_sw, legal;
        int         n;
        int         st[4];
        int         s;
        logic       zf_now;
        logic [1:0] aop;
        op    = ins[31:26];
        is_r  = (op == 6'b000000);
        is_lw = (op == 6'b100011);
        is_sw = (op == 6'b101011);
        legal = is_r || is_lw || is_sw;
        aop   = is_r ? 2'b10 : 2'b00;
        st    = '{S_DEC, S_EXE, S_MEM, S_WB};
        if (is_r) begin
            st[2] = S_WB;
            n = 3;
        end else if (is_lw) begin
            n = 4;
        end else if (is_sw) begin
            n = 3;
        end else begin
            n = 1;
        end
        check_idle("pre");
        instr_valid = 1'b1;
        instr = ins;
        alu_zf = 1'($urandom_range(0, 1));
        for (int k = 1; k <= n; k++) begin
            tick();
            s = st[k-1];
            instr_valid = 1'($urandom_range(0, 1));
            instr = $urandom();
            zf_now = zf_force_en ? zf_force_val : 1'($urandom_range(0, 1));
            alu_zf = zf_now;
            check("ctl", 64'(ctl), 64'(exp_ctl(0, s == S_WB,
                  is_lw && (s == S_MEM || s == S_WB), is_sw && s == S_MEM,
                  is_lw && (s == S_MEM || s == S_WB), aop,
                  legal && k == n, !legal && s == S_DEC)));
            check("regs", 64'({ra1, ra2, funct}),
                  64'({ins[25:21], ins[20:16], ins[5:0]}));
            if (is_r || is_lw)
                check("wa", 64'(wa), 64'(is_r ? ins[15:11] : ins[20:16]));
            check("zf", 64'(zf_out), 64'(m_zf));
            check("cnt", 64'(retired_cnt), 64'(m_cnt));
            if (s == S_EXE) m_zf = zf_now;
        end
        tick();
        instr_valid = 1'b0;
`ifdef SEQ_RETIRE_CNT_EN
        if (legal) m_cnt = m_cnt + 16'd1;
`endif
        check_idle("post");
    endtask

    initial begin
        logic [31:0] r;
        logic [5:0]  op;
        rst = 1'b1;
        instr_valid = 1'b0;
        instr = '0;
        alu_zf = 1'b0;
        m_zf = 1'b0;
        m_cnt = '0;
        repeat (2) tick();
        check("reset_all", 64'(all_out), 64'd0);
        rst = 1'b0;
        repeat (2) tick();
        check_idle("after_reset");

        run_instr(32'h012A4020);
        run_instr({6'b100011, 5'd4, 5'd9, 16'h1234});
        run_instr({6'b101011, 5'd7, 5'd12, 16'h0040});
        run_instr({6'b111111, 26'h2ABCDEF});

        zf_force_en = 1'b1;
        zf_force_val = 1'b1;
        run_instr(32'h012A4020);
        zf_force_val = 1'b0;
        run_instr({6'b101011, 5'd1, 5'd2, 16'h0});
        zf_force_en = 1'b0;

        // Reset while an LW sits in EXEC.
        check_idle("lw_rst_pre");
        instr_valid = 1'b1;
        instr = {6'b100011, 5'd3, 5'd9, 16'h0};
        tick();
        instr_valid = 1'b0;
        tick();
        check("lw_exec_ra2", 64'(ra2), 64'd9);
        #2 rst = 1'b1;
        #1 check("rst_async", 64'(all_out), 64'd0);
        tick();
        check("rst_held", 64'(all_out), 64'd0);
        rst = 1'b0;
        m_zf = 1'b0;
        m_cnt = '0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_no_pulse", 64'({RegWrite, MemToWrite, done}), 64'd0);
        end
        check_idle("rst_release");

        for (int i = 0; i < 150; i++) begin
            idle_cycles($urandom_range(0, 2));
            r = $urandom();
            case ($urandom_range(0, 3))
                0: op = 6'b000000;
                1: op = 6'b100011;
                2: op = 6'b101011;
                default: op = 6'($urandom_range(0, 63));
            endcase
            run_instr({op, r[25:0]});
        end

`ifdef SEQ_RETIRE_CNT_EN
        while (m_cnt != 16'hFFFF) run_instr(32'h012A4020);
        check("cnt_full", 64'(retired_cnt), 64'hFFFF);
        zf_force_en = 1'b1;
        zf_force_val = 1'b1;
        run_instr(32'h012A4020);
        zf_force_en = 1'b0;
        check("cnt_wrap", 64'(retired_cnt), 64'h0000);
        check("wrap_zf", 64'(zf_out), 64'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
